// File: rtl/iobus_uart_tx_if.sv
// OTTER IOBUS bundle between the MCU and the UART transmitter's registers.
// The MCU drives address, write data and the write strobe; the
// transmitter returns combinational read data for the addressed register.
interface iobus_uart_tx_if;
   logic [31:0] IOBUS_ADDR;
   logic [31:0] IOBUS_OUT;
   logic        IOBUS_WR;
   logic [31:0] RD_DATA;

   modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR, input  RD_DATA);
   modport slave  (input  IOBUS_ADDR, input  IOBUS_OUT, input  IOBUS_WR, output RD_DATA);
endinterface

// File: rtl/iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the OTTER IOBUS.
// Registers: DATA (+0) pushes a byte into a small TX FIFO, STATUS (+4)
// reports FIFO/FSM state and holds a sticky overflow flag, and CTRL (+8)
// holds the transmit enable and the "drained" interrupt enable.
module iobus_uart_tx #(
   parameter logic [31:0] BASE_AD      = 32'h1100_0060,
   parameter int          CLKS_PER_BIT = 434,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic           CLK,
   input  logic           RST_N,
   iobus_uart_tx_if.slave bus,
   output logic           TX,
   output logic           IRQ
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT);

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [4:0]    DEPTH_CNT = 5'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // Register decode
   logic sel_data, sel_stat, sel_ctrl;
   logic wr_data, wr_stat, wr_ctrl;

   // Control and status state
   logic en, irq_en, overflow;

   // FIFO
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [4:0]    count;
   logic          full, empty, push, pop;

   // Transmitter
   logic [1:0]    state;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          busy, baud_done;

   // Upper write-data bits have no register behind them.
   logic unused_bus_bits;
   assign unused_bus_bits = ^bus.IOBUS_OUT[31:8];

   assign sel_data = (bus.IOBUS_ADDR == BASE_AD);
   assign sel_stat = (bus.IOBUS_ADDR == BASE_AD + 32'd4);
   assign sel_ctrl = (bus.IOBUS_ADDR == BASE_AD + 32'd8);

   assign wr_data = bus.IOBUS_WR & sel_data;
   assign wr_stat = bus.IOBUS_WR & sel_stat;
   assign wr_ctrl = bus.IOBUS_WR & sel_ctrl;

   assign full  = (count == DEPTH_CNT);
   assign empty = (count == 5'd0);
   assign busy  = (state != ST_IDLE);

   // The FSM takes the head byte whenever it sits idle with work queued.
   assign pop = (state == ST_IDLE) & en & ~empty;
   // A push into a full FIFO still fits when the head leaves in the same cycle.
   assign push = wr_data & (~full | pop);

   assign baud_done = (baud_cnt == BAUD_LAST);

   // Combinational read mux; addresses outside this block read as zero
   always_comb begin
      // NOTE: RD_DATA gets a default before any condition so every path assigns it and no latch is inferred.
      bus.RD_DATA = 32'd0;
      if (sel_stat) begin
         bus.RD_DATA = {19'd0, count, 4'd0, overflow, busy, empty, full};
      end else if (sel_ctrl) begin
         bus.RD_DATA = {30'd0, irq_en, en};
      end
   end

   // CTRL register and sticky overflow flag
   always_ff @(posedge CLK or negedge RST_N) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!RST_N) begin
         en       <= 1'b1;
         irq_en   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            en     <= bus.IOBUS_OUT[0];
            irq_en <= bus.IOBUS_OUT[1];
         end
         if (wr_data & full & ~pop) begin
            overflow <= 1'b1;
         end else if (wr_stat & bus.IOBUS_OUT[3]) begin
            overflow <= 1'b0;
         end
      end
   end

   // FIFO storage, written on every accepted push
   always_ff @(posedge CLK) begin
      // NOTE: the storage array is deliberately not reset; pointers and count alone say which entries are valid.
      if (push) begin
         mem[wr_ptr] <= bus.IOBUS_OUT[7:0];
      end
   end

   // FIFO pointers (wrap naturally at the power-of-two depth) and occupancy
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= 5'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + 5'd1;
            2'b01:   count <= count - 5'd1;
            default: count <= count;
         endcase
      end
   end

   // Transmit FSM: start bit, eight data bits LSB first, stop bit
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= ST_IDLE;
         TX       <= 1'b1;
         baud_cnt <= '0;
         bit_idx  <= 3'd0;
         shreg    <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  shreg    <= mem[rd_ptr];
                  TX       <= 1'b0;
                  baud_cnt <= '0;
                  state    <= ST_START;
               end
            end
            ST_START: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  TX       <= shreg[0];
                  shreg    <= {1'b0, shreg[7:1]};
                  bit_idx  <= 3'd0;
                  state    <= ST_DATA;
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            ST_DATA: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     TX    <= 1'b1;
                     state <= ST_STOP;
                  end else begin
                     TX      <= shreg[0];
                     shreg   <= {1'b0, shreg[7:1]};
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            ST_STOP: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  state    <= ST_IDLE;
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            default: begin
               TX    <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Level interrupt: enabled, nothing queued and the line back at idle
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         IRQ <= 1'b0;
      end else begin
         IRQ <= irq_en & empty & (state == ST_IDLE);
      end
   end

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Self-checking bench for iobus_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// Register accesses are table driven; serial output is decoded by a line
// monitor and compared against a queue of bytes the bench has written.
module tb_iobus_uart_tx;
   localparam logic [31:0] BASE   = 32'h1100_0060;
   localparam int          CPB    = 4;
   localparam int          DEPTH  = 8;
   localparam int          FRAME  = 10 * CPB;
   localparam logic [31:0] A_DATA = BASE;
   localparam logic [31:0] A_STAT = BASE + 32'd4;
   localparam logic [31:0] A_CTRL = BASE + 32'd8;

   logic CLK = 1'b0;
   logic RST_N;
   logic TX, IRQ;

   iobus_uart_tx_if ibus ();

   iobus_uart_tx #(
      .BASE_AD      (BASE),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (ibus.slave),
      .TX    (TX),
      .IRQ   (IRQ)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   logic [7:0] exp_q[$];

   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] raddr;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 32'h%08h, expected 32'h%08h", name, act, exp);
   endtask

   // STATUS word assembled from the documented field positions.
   function automatic logic [31:0] status_word(input int cnt, input bit ovf, input bit bsy);
      int v;
      v = (cnt << 8) | (int'(ovf) << 3) | (int'(bsy) << 2)
        | (int'(cnt == 0) << 1) | int'(cnt == DEPTH);
      return 32'(v);
   endfunction

   // Expected line level k cycles after the start bit begins.
   function automatic logic line_level(input logic [7:0] b, input int k);
      int slot;
      slot = k / CPB;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
      return 1'b1;
   endfunction

   // Call at (or just after) a falling edge; returns after the next falling edge.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      ibus.IOBUS_ADDR = a;
      ibus.IOBUS_OUT  = d;
      ibus.IOBUS_WR   = 1'b1;
      @(negedge CLK);
      ibus.IOBUS_WR   = 1'b0;
      ibus.IOBUS_OUT  = 32'd0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      ibus.IOBUS_ADDR = a;
      #1;
      d = ibus.RD_DATA;
   endtask

   // Wait (bounded) for a start bit, then sample each bit at mid-cell.
   task automatic rx_frame(input int budget, output logic [7:0] b, output int st,
                           output bit got, output bit frm_ok);
      got = 1'b0; frm_ok = 1'b1; b = 8'd0; st = 0;
      for (int i = 0; i < budget; i++) begin
         if (TX === 1'b0) begin
            got = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      if (!got) return;
      st = cyc;
      repeat (CPB / 2) @(negedge CLK);
      if (TX !== 1'b0) frm_ok = 1'b0;
      for (int j = 0; j < 8; j++) begin
         repeat (CPB) @(negedge CLK);
         b[j] = TX;
      end
      repeat (CPB) @(negedge CLK);
      if (TX !== 1'b1) frm_ok = 1'b0;
   endtask

   // Receive n frames, matching each against the head of exp_q.
   task automatic rx_expect(input string tag, input int n, input bit chk_gap);
      int prev_st = 0;
      for (int i = 0; i < n; i++) begin
         logic [7:0] b, want;
         int st;
         bit got, frm_ok;
         rx_frame(600, b, st, got, frm_ok);
         check($sformatf("%s frame%0d seen", tag, i), 32'(got), 32'd1);
         if (!got) return;
         if (exp_q.size() > 0) want = exp_q.pop_front();
         else want = 8'hxx;
         check($sformatf("%s frame%0d data", tag, i), 32'(b), 32'(want));
         check($sformatf("%s frame%0d framing", tag, i), 32'(frm_ok), 32'd1);
         if (chk_gap && i > 0)
            check($sformatf("%s frame%0d spacing", tag, i), 32'(st - prev_st), 32'(FRAME + 1));
         prev_st = st;
      end
   endtask

   // Line must stay idle for n cycles.
   task automatic expect_quiet(input string tag, input int n);
      bit quiet = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         if (TX !== 1'b1) quiet = 1'b0;
      end
      check(tag, 32'(quiet), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;

      tbl[0]  = '{1'b0, 32'd0,            32'd0,         A_STAT,        32'h0000_0002};
      tbl[1]  = '{1'b0, 32'd0,            32'd0,         A_CTRL,        32'h0000_0001};
      tbl[2]  = '{1'b0, 32'd0,            32'd0,         A_DATA,        32'h0000_0000};
      tbl[3]  = '{1'b0, 32'd0,            32'd0,         BASE + 32'd12, 32'h0000_0000};
      tbl[4]  = '{1'b0, 32'd0,            32'd0,         32'h1100_0000, 32'h0000_0000};
      tbl[5]  = '{1'b1, BASE + 32'd12,    32'hFFFF_FFFF, A_CTRL,        32'h0000_0001};
      tbl[6]  = '{1'b1, BASE + 32'd12,    32'h0000_00FF, A_STAT,        32'h0000_0002};
      tbl[7]  = '{1'b1, 32'h1100_0000,    32'hFFFF_FFFF, A_CTRL,        32'h0000_0001};
      tbl[8]  = '{1'b1, 32'h1100_0000,    32'h0000_00A5, A_STAT,        32'h0000_0002};
      tbl[9]  = '{1'b1, A_STAT,           32'hFFFF_FFFF, A_STAT,        32'h0000_0002};
      tbl[10] = '{1'b1, A_CTRL,           32'hFFFF_FFFC, A_CTRL,        32'h0000_0000};
      tbl[11] = '{1'b1, A_CTRL,           32'hFFFF_FFFE, A_CTRL,        32'h0000_0002};
      tbl[12] = '{1'b1, A_CTRL,           32'h0000_0001, A_CTRL,        32'h0000_0001};
      tbl[13] = '{1'b0, 32'd0,            32'd0,         BASE + 32'd16, 32'h0000_0000};

      ibus.IOBUS_ADDR = 32'd0;
      ibus.IOBUS_OUT  = 32'd0;
      ibus.IOBUS_WR   = 1'b0;
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      check("reset tx", 32'(TX), 32'd1);
      check("reset irq", 32'(IRQ), 32'd0);
      RST_N = 1'b1;
      @(negedge CLK);

      // Register access and address decode
      foreach (tbl[i]) begin
         if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].wdata);
         bus_read(tbl[i].raddr, r);
         check($sformatf("reg vec%0d", i), r, tbl[i].exp);
      end
      repeat (3) @(negedge CLK);
      check("decode irq", 32'(IRQ), 32'd0);
      check("decode tx idle", 32'(TX), 32'd1);

      // First byte: exact per-cycle waveform and busy flag
      bus_read(A_STAT, r);
      check("t1 status idle", r, status_word(0, 1'b0, 1'b0));
      bus_write(A_DATA, 32'h0000_00A5);
      bus_read(A_STAT, r);
      check("t1 count after write", r, status_word(1, 1'b0, 1'b0));
      check("t1 tx before start", 32'(TX), 32'd1);
      for (int k = 0; k < FRAME; k++) begin
         @(negedge CLK);
         #1;
         check($sformatf("t1 tx cyc%0d", k), 32'(TX), 32'(line_level(8'hA5, k)));
         check($sformatf("t1 status cyc%0d", k), ibus.RD_DATA, status_word(0, 1'b0, 1'b1));
      end
      @(negedge CLK);
      #1;
      check("t1 tx after stop", 32'(TX), 32'd1);
      check("t1 status after stop", ibus.RD_DATA, status_word(0, 1'b0, 1'b0));

      // Fill past capacity with EN=0, clear overflow, then drain
      @(negedge CLK);
      bus_write(A_CTRL, 32'd0);
      for (int i = 0; i < 9; i++) begin
         bus_write(A_DATA, 32'(i));
         if (i < DEPTH) exp_q.push_back(8'(i));
      end
      bus_read(A_STAT, r);
      check("t2 status overflowed", r, status_word(8, 1'b1, 1'b0));
      check("t2 tx held idle", 32'(TX), 32'd1);
      bus_write(A_STAT, 32'h0000_0008);
      bus_read(A_STAT, r);
      check("t2 overflow cleared", r, status_word(8, 1'b0, 1'b0));
      bus_write(A_CTRL, 32'd1);
      rx_expect("t2", DEPTH, 1'b1);
      expect_quiet("t2 no ninth frame", 100);
      bus_read(A_STAT, r);
      check("t2 drained", r, status_word(0, 1'b0, 1'b0));

      // Push into a full FIFO on the exact edge of a pop
      @(negedge CLK);
      bus_write(A_CTRL, 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         bus_write(A_DATA, 32'h10 + 32'(i));
         exp_q.push_back(8'h10 + 8'(i));
      end
      bus_read(A_STAT, r);
      check("t3 full before", r, status_word(8, 1'b0, 1'b0));
      bus_write(A_CTRL, 32'd1);
      bus_write(A_DATA, 32'h18);
      exp_q.push_back(8'h18);
      bus_read(A_STAT, r);
      check("t3 push+pop while full", r, status_word(8, 1'b0, 1'b1));
      rx_expect("t3", DEPTH + 1, 1'b1);
      expect_quiet("t3 quiet after", 20);
      bus_read(A_STAT, r);
      check("t3 drained", r, status_word(0, 1'b0, 1'b0));

      // Interrupt timing around a single frame
      @(negedge CLK);
      bus_write(A_CTRL, 32'd3);
      check("t4 irq lags enable", 32'(IRQ), 32'd0);
      @(negedge CLK);
      check("t4 irq set", 32'(IRQ), 32'd1);
      bus_write(A_DATA, 32'h3C);
      check("t4 irq at write edge", 32'(IRQ), 32'd1);
      for (int k = 1; k <= FRAME + 1; k++) begin
         @(negedge CLK);
         check($sformatf("t4 irq low cyc%0d", k), 32'(IRQ), 32'd0);
      end
      @(negedge CLK);
      check("t4 irq after drain", 32'(IRQ), 32'd1);

      // Random bytes at random spacing while transmitting
      repeat (5) @(negedge CLK);
      fork
         begin
            for (int i = 0; i < 12; i++) begin
               logic [7:0] b;
               repeat ($urandom_range(20, 60)) @(negedge CLK);
               b = 8'($urandom);
               bus_write(A_DATA, 32'(b));
               exp_q.push_back(b);
            end
         end
         rx_expect("rand", 12, 1'b0);
      join
      repeat (5) @(negedge CLK);
      bus_read(A_STAT, r);
      check("rand final status", r, status_word(0, 1'b0, 1'b0));
      check("rand queue consumed", 32'(exp_q.size()), 32'd0);
      check("rand irq", 32'(IRQ), 32'd1);

      // Asynchronous reset during data bit 3
      @(negedge CLK);
      bus_write(A_DATA, 32'h00);
      bus_write(A_DATA, 32'h00);
      bus_write(A_DATA, 32'h00);
      repeat (16) @(negedge CLK);
      #1;
      check("t5 tx low in bit3", 32'(TX), 32'd0);
      RST_N = 1'b0;
      #1;
      check("t5 tx async high", 32'(TX), 32'd1);
      check("t5 irq async low", 32'(IRQ), 32'd0);
      bus_read(A_STAT, r);
      check("t5 status in reset", r, status_word(0, 1'b0, 1'b0));
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      expect_quiet("t5 no residual frame", 100);
      bus_read(A_STAT, r);
      check("t5 status after", r, status_word(0, 1'b0, 1'b0));
      bus_read(A_CTRL, r);
      check("t5 ctrl after", r, 32'h0000_0001);
      check("t5 irq after", 32'(IRQ), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
